// File: rtl/mvm_ctrl_pipe.sv
// MVM read sequencer: walks every vector chunk for each matrix row, issues SRAM
// read addresses, and delays accumulator tags by RD_LAT to line up with read data.
module mvm_ctrl_pipe #(
   parameter int VEC_ADDRW = 8,
   parameter int MAT_ADDRW = 9,
   parameter int VEC_SIZEW = VEC_ADDRW + 1,
   parameter int MAT_SIZEW = MAT_ADDRW + 1,
   parameter int RD_LAT    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [VEC_ADDRW-1:0] vec_start_addr,
   input  logic [VEC_SIZEW-1:0] vec_num_words,
   input  logic [MAT_ADDRW-1:0] mat_start_addr,
   input  logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
   input  logic [MAT_ADDRW-1:0] mat_row_stride,
   input  logic                 stall,
   input  logic                 abort,
   output logic                 rd_en,
   output logic [VEC_ADDRW-1:0] vec_raddr,
   output logic [MAT_ADDRW-1:0] mat_raddr,
   output logic                 accum_first,
   output logic                 accum_last,
   output logic                 ovalid,
   output logic [MAT_SIZEW-1:0] orow,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam int DW = 4;

   state_t               state, state_nxt;
   logic [VEC_ADDRW-1:0] vec_start_q;
   logic [VEC_SIZEW-1:0] n_q, chunk_q;
   logic [MAT_SIZEW-1:0] r_q, row_q;
   logic [MAT_ADDRW-1:0] stride_q, row_base_q;
   logic [DW-1:0]        drain_q;
   logic                 done_q, cfg_err_q;

   // Tag pipeline: stage 1 is loaded at issue, stage RD_LAT lines up with read data.
   logic [RD_LAT:1]                vld_pipe, first_pipe, last_pipe;
   logic [RD_LAT:1][MAT_SIZEW-1:0] row_pipe;

   logic accept, issue, finish, zero_cfg, last_chunk, last_row;

   assign zero_cfg   = (vec_num_words == '0) || (mat_num_rows_per_olane == '0);
   assign last_chunk = (chunk_q == n_q - VEC_SIZEW'(1));
   assign last_row   = (row_q == r_q - MAT_SIZEW'(1));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      issue     = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
            if (start && !zero_cfg) state_nxt = RUN;
         end
         RUN: begin
            if (abort) state_nxt = IDLE;
            else if (!stall) begin
               issue = 1'b1;
               if (last_chunk && last_row) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (abort) state_nxt = IDLE;
            else if (drain_q == DW'(RD_LAT - 1)) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         vec_start_q <= '0;
         n_q         <= '0;
         r_q         <= '0;
         stride_q    <= '0;
         chunk_q     <= '0;
         row_q       <= '0;
         row_base_q  <= '0;
         drain_q     <= '0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= finish || (accept && zero_cfg);
         if (accept) begin
            vec_start_q <= vec_start_addr;
            n_q         <= vec_num_words;
            r_q         <= mat_num_rows_per_olane;
            stride_q    <= mat_row_stride;
            row_base_q  <= mat_start_addr;
            chunk_q     <= '0;
            row_q       <= '0;
            drain_q     <= '0;
            cfg_err_q   <= zero_cfg;
         end else if (issue) begin
            // row_base tracks mat_start + row*stride incrementally
            if (last_chunk) begin
               chunk_q    <= '0;
               row_q      <= row_q + MAT_SIZEW'(1);
               row_base_q <= row_base_q + stride_q;
            end else begin
               chunk_q <= chunk_q + VEC_SIZEW'(1);
            end
         end else if (state == DRAIN) begin
            drain_q <= drain_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe   <= '0;
         first_pipe <= '0;
         last_pipe  <= '0;
         row_pipe   <= '0;
      end else if (abort && state != IDLE) begin
         vld_pipe   <= '0;
         first_pipe <= '0;
         last_pipe  <= '0;
         row_pipe   <= '0;
      end else begin
         vld_pipe[1]   <= issue;
         first_pipe[1] <= issue && (chunk_q == '0);
         last_pipe[1]  <= issue && last_chunk;
         row_pipe[1]   <= issue ? row_q : '0;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i]   <= vld_pipe[i-1];
            first_pipe[i] <= first_pipe[i-1];
            last_pipe[i]  <= last_pipe[i-1];
            row_pipe[i]   <= row_pipe[i-1];
         end
      end
   end

   assign rd_en       = issue;
   assign vec_raddr   = (state == RUN) ? vec_start_q + VEC_ADDRW'(chunk_q) : '0;
   assign mat_raddr   = (state == RUN) ? row_base_q + MAT_ADDRW'(chunk_q) : '0;
   assign accum_first = vld_pipe[RD_LAT] & first_pipe[RD_LAT];
   assign accum_last  = vld_pipe[RD_LAT] & last_pipe[RD_LAT];
   assign ovalid      = accum_last;
   assign orow        = vld_pipe[RD_LAT] ? row_pipe[RD_LAT] : '0;
   assign busy        = (state != IDLE);
   assign done        = done_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_mvm_ctrl_pipe.sv
// Bench for mvm_ctrl_pipe: arithmetic job model checked every cycle, plus
// hand-computed address/tag/timing expectations for directed jobs.
module tb_mvm_ctrl_pipe;
   localparam int VA = 8, MA = 9, VS = 9, MS = 10, LAT = 2;

   logic clk = 0, rst = 0, start = 0, stall = 0, abort = 0;
   logic [VA-1:0] vec_start_addr = '0;
   logic [VS-1:0] vec_num_words = '0;
   logic [MA-1:0] mat_start_addr = '0, mat_row_stride = '0;
   logic [MS-1:0] mat_num_rows_per_olane = '0;
   logic rd_en, accum_first, accum_last, ovalid, busy, done, cfg_err;
   logic [VA-1:0] vec_raddr;
   logic [MA-1:0] mat_raddr;
   logic [MS-1:0] orow;

   mvm_ctrl_pipe #(.VEC_ADDRW(VA), .MAT_ADDRW(MA), .VEC_SIZEW(VS), .MAT_SIZEW(MS), .RD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_start_addr(vec_start_addr),
      .vec_num_words(vec_num_words), .mat_start_addr(mat_start_addr),
      .mat_num_rows_per_olane(mat_num_rows_per_olane), .mat_row_stride(mat_row_stride),
      .stall(stall), .abort(abort), .rd_en(rd_en), .vec_raddr(vec_raddr), .mat_raddr(mat_raddr),
      .accum_first(accum_first), .accum_last(accum_last), .ovalid(ovalid), .orow(orow),
      .busy(busy), .done(done), .cfg_err(cfg_err));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   wire [33:0] act_bus = {rd_en, vec_raddr, mat_raddr, accum_first, accum_last, ovalid, orow,
                          busy, done, cfg_err};

   // Job model: issue index k walks 0..N*R-1; addresses come straight from k.
   typedef struct packed {logic v, f, l; logic [MS-1:0] row;} tag_t;
   tag_t tq[$];
   bit   m_run, m_done, m_cfg;
   int   m_k, m_n, m_r, m_vs, m_ms, m_st, m_drain, cyc;

   // Monitor records for the directed checks.
   int vec_q[$], mat_q[$], rdcyc_q[$], orow_q[$], of_q[$], ovcyc_q[$], donecyc_q[$];
   int busy_cnt = 0, last_cnt = 0;

   task automatic model_reset();
      m_run = 0; m_done = 0; m_cfg = 0; m_drain = 0; m_k = 0;
      tq.delete();
      repeat (LAT) tq.push_back('0);
   endtask

   initial model_reset();

   always @(negedge clk) begin
      logic [33:0] e;
      tag_t t, cur;
      bit nd;
      cyc++;
      if (!rst) begin
         model_reset();
         check($sformatf("cyc%0d outputs in reset", cyc), act_bus, '0);
      end else begin
         t = tq[0];
         e = {m_run && !stall && !abort,
              m_run ? VA'(m_vs + m_k % m_n) : VA'(0),
              m_run ? MA'(m_ms + (m_k / m_n) * m_st + m_k % m_n) : MA'(0),
              t.v & t.f, t.v & t.l, t.v & t.l, t.v ? t.row : MS'(0),
              m_run || m_drain > 0, m_done, m_cfg};
         check($sformatf("cyc%0d outputs", cyc), act_bus, e);
         cur = '0; nd = 0;
         if ((m_run || m_drain > 0) && abort) begin
            m_run = 0; m_drain = 0;
            tq.delete();
            repeat (LAT) tq.push_back('0);
         end else begin
            if (m_run) begin
               if (!stall) begin
                  cur.v = 1; cur.f = (m_k % m_n == 0); cur.l = (m_k % m_n == m_n - 1);
                  cur.row = MS'(m_k / m_n);
                  m_k++;
                  if (m_k == m_n * m_r) begin m_run = 0; m_drain = LAT; end
               end
            end else if (m_drain > 0) begin
               m_drain--;
               if (m_drain == 0) nd = 1;
            end else if (start) begin
               m_vs = int'(vec_start_addr); m_n = int'(vec_num_words);
               m_ms = int'(mat_start_addr); m_r = int'(mat_num_rows_per_olane);
               m_st = int'(mat_row_stride);
               m_cfg = (m_n == 0 || m_r == 0);
               if (m_cfg) nd = 1; else begin m_run = 1; m_k = 0; end
            end
            void'(tq.pop_front());
            tq.push_back(cur);
         end
         m_done = nd;
         if (rd_en) begin vec_q.push_back(int'(vec_raddr)); mat_q.push_back(int'(mat_raddr)); rdcyc_q.push_back(cyc); end
         if (ovalid) begin orow_q.push_back(int'(orow)); of_q.push_back(int'(accum_first)); ovcyc_q.push_back(cyc); end
         if (accum_last) last_cnt++;
         if (busy) busy_cnt++;
         if (done) donecyc_q.push_back(cyc);
      end
   end

   task automatic do_start(input int vs, input int n, input int ms, input int st, input int r);
      @(posedge clk); #1;
      vec_start_addr = VA'(vs); vec_num_words = VS'(n); mat_start_addr = MA'(ms);
      mat_row_stride = MA'(st); mat_num_rows_per_olane = MS'(r); start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic wait_idle(input int bound);
      int i = 0;
      while (busy && i < bound) begin @(posedge clk); #1; i++; end
      check("wait for idle timeout", i >= bound, 0);
      @(posedge clk); #1;
   endtask

   int b, bb, lb, db, ob;
   int exp_mat[6] = '{10, 11, 12, 13, 14, 15};
   int exp_vec[6] = '{4, 5, 6, 4, 5, 6};
   int exp_wrap[4] = '{510, 511, 3, 4};

   task automatic snap();
      b = vec_q.size(); bb = busy_cnt; lb = last_cnt; db = donecyc_q.size(); ob = orow_q.size();
   endtask

   task automatic basic_checks(input string tag, input int busy_len);
      check({tag, " rd count"}, vec_q.size() - b, 6);
      if (vec_q.size() - b == 6)
         for (int i = 0; i < 6; i++) begin
            check($sformatf("%s mat_raddr[%0d]", tag, i), mat_q[b+i], exp_mat[i]);
            check($sformatf("%s vec_raddr[%0d]", tag, i), vec_q[b+i], exp_vec[i]);
         end
      check({tag, " busy cycles"}, busy_cnt - bb, busy_len);
      check({tag, " done count"}, donecyc_q.size() - db, 1);
      if (donecyc_q.size() - db == 1 && vec_q.size() - b == 6)
         check({tag, " done delay"}, donecyc_q[db] - rdcyc_q[b], busy_len);
      check({tag, " ovalid count"}, orow_q.size() - ob, 2);
      if (orow_q.size() - ob == 2 && vec_q.size() - b == 6) begin
         check({tag, " orow0"}, orow_q[ob], 0);
         check({tag, " orow1"}, orow_q[ob+1], 1);
         check({tag, " row1 tag lag"}, ovcyc_q[ob+1] - rdcyc_q[b+5], LAT);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 check("outputs during reset", act_bus, '0);
      rst = 1;
      @(posedge clk); #1;

      // basic job
      snap();
      do_start(4, 3, 10, 3, 2);
      wait_idle(50);
      basic_checks("basic", 8);
      if (orow_q.size() - ob == 2 && vec_q.size() - b == 6)
         check("basic row0 tag lag", ovcyc_q[ob] - rdcyc_q[b+2], LAT);

      // stride gap with address wrap
      snap();
      do_start(0, 2, 510, 5, 2);
      wait_idle(50);
      check("wrap rd count", vec_q.size() - b, 4);
      if (vec_q.size() - b == 4)
         for (int i = 0; i < 4; i++) check($sformatf("wrap mat_raddr[%0d]", i), mat_q[b+i], exp_wrap[i]);

      // 3-cycle stall mid-row
      snap();
      do_start(4, 3, 10, 3, 2);
      @(posedge clk); #1;
      @(posedge clk); #1 stall = 1;
      repeat (3) begin @(posedge clk); #1; end
      stall = 0;
      wait_idle(50);
      basic_checks("stall", 11);
      if (vec_q.size() - b == 6) check("stall issue gap", rdcyc_q[b+2] - rdcyc_q[b+1], 4);

      // zero-size config
      snap();
      do_start(0, 0, 0, 1, 3);
      check("zero cfg_err", cfg_err, 1);
      check("zero done", done, 1);
      check("zero busy", busy, 0);
      repeat (3) begin @(posedge clk); #1; end
      check("zero no reads", vec_q.size() - b, 0);
      do_start(4, 3, 10, 3, 2);
      check("cfg_err cleared", cfg_err, 0);
      wait_idle(50);

      // abort in DRAIN
      snap();
      do_start(4, 3, 10, 3, 2);
      repeat (6) begin @(posedge clk); #1; end
      check("abort busy in drain", busy, 1);
      abort = 1;
      @(posedge clk); #1 abort = 0;
      check("abort idle next", busy, 0);
      repeat (5) begin @(posedge clk); #1; end
      check("abort accum_last count", last_cnt - lb, 1);
      check("abort no done", donecyc_q.size() - db, 0);
      snap();
      do_start(4, 3, 10, 3, 2);
      wait_idle(50);
      basic_checks("after abort", 8);

      // N=1, R=4
      snap();
      do_start(7, 1, 20, 2, 4);
      wait_idle(50);
      check("n1 ovalid count", orow_q.size() - ob, 4);
      if (orow_q.size() - ob == 4)
         for (int i = 0; i < 4; i++) begin
            check($sformatf("n1 orow[%0d]", i), orow_q[ob+i], i);
            check($sformatf("n1 first[%0d]", i), of_q[ob+i], 1);
         end
      check("n1 last count", last_cnt - lb, 4);

      // start held high across done restarts each time
      snap();
      @(posedge clk); #1;
      vec_num_words = 1; mat_num_rows_per_olane = 1; start = 1;
      repeat (10) begin @(posedge clk); #1; end
      start = 0;
      wait_idle(50);
      check("held start done count", donecyc_q.size() - db, 3);

      // asynchronous reset mid-RUN
      do_start(4, 3, 10, 3, 2);
      @(posedge clk); #2 rst = 0;
      #1 check("async reset outputs", act_bus, '0);
      @(posedge clk); #1 rst = 1;
      snap();
      do_start(4, 3, 10, 3, 2);
      wait_idle(50);
      basic_checks("after reset", 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
